// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer:
// op encodings, FSM states and the iteration count.
package hilo_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam int ITERS = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX
    } hilo_state_t;

endpackage

// File: rtl/hilo_muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on a
// double-width accumulator {upper, lower}.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 i_div,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_opnd,
    output logic [2*WIDTH-1:0]   o_acc
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_diff;

    always_comb begin
        // Multiply: lower half holds the remaining multiplier bits, LSB first.
        w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
        // Divide: upper half is the partial remainder, lower half the
        // dividend bits being shifted out while quotient bits shift in.
        w_rem_sh = i_acc[2*WIDTH-1:WIDTH-1];
        w_diff   = w_rem_sh - {1'b0, i_opnd};
        if (!i_div) begin
            o_acc = {w_sum, i_acc[WIDTH-1:1]};
        end else if (!w_diff[WIDTH]) begin
            o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
        end else begin
            o_acc = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair;
// fixed 34-cycle busy window, plus single-cycle MTHI/MTLO writes.
module hilo_muldiv
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(ITERS);

    hilo_state_t        r_state;
    hilo_state_t        w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_acc_step;
    logic [WIDTH-1:0]   r_a, r_b, r_opnd, r_hi, r_lo;
    logic               r_div, r_signed, r_neg_q, r_neg_r, r_done;

    logic               w_md_op, w_accept;
    logic               w_neg_a, w_neg_b;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot, w_rem;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_div  (r_div),
        .i_acc  (r_acc),
        .i_opnd (r_opnd),
        .o_acc  (w_acc_step)
    );

    always_comb begin
        w_md_op  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
        w_accept = start && !flush && (r_state == S_IDLE);
        w_neg_a  = r_signed && r_a[WIDTH-1];
        w_neg_b  = r_signed && r_b[WIDTH-1];
        w_abs_a  = w_neg_a ? -r_a : r_a;
        w_abs_b  = w_neg_b ? -r_b : r_b;
        w_prod   = r_neg_q ? -r_acc : r_acc;
        w_quot   = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept && w_md_op) w_state_next = S_PREP;
            S_PREP: w_state_next = S_CALC;
            S_CALC: if (r_cnt == CNT_W'(ITERS - 1)) w_state_next = S_FIX;
            S_FIX:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (flush) w_state_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_opnd   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_div    <= 1'b0;
            r_signed <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_md_op) begin
                            r_a      <= src_a;
                            r_b      <= src_b;
                            r_div    <= (op == OP_DIV) || (op == OP_DIVU);
                            r_signed <= (op == OP_MULT) || (op == OP_DIV);
                        end else if (op == OP_MTHI) begin
                            r_hi <= src_a;
                        end else if (op == OP_MTLO) begin
                            r_lo <= src_a;
                        end
                    end
                end
                S_PREP: begin
                    // Divide iterates on the dividend, multiply on the multiplier.
                    r_acc   <= {{WIDTH{1'b0}}, (r_div ? w_abs_a : w_abs_b)};
                    r_opnd  <= r_div ? w_abs_b : w_abs_a;
                    r_neg_q <= w_neg_a ^ w_neg_b;
                    r_neg_r <= w_neg_a;
                    r_cnt   <= '0;
                end
                S_CALC: begin
                    r_acc <= w_acc_step;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    if (!flush) begin
                        r_done <= 1'b1;
                        if (!r_div) begin
                            r_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod[WIDTH-1:0];
                        end else if (r_b == '0) begin
                            r_hi <= r_a;
                            r_lo <= '1;
                        end else begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: stimulus pushes expected HI/LO from an
// arithmetic reference model; a negedge monitor checks each done pulse.
module tb_hilo_muldiv;
    import hilo_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    hilo_muldiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          c0;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          passed = 0;
    int          total = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    // Reference: plain 64-bit arithmetic; SV signed division truncates toward
    // zero and the remainder follows the dividend, as MIPS requires.
    function automatic logic [63:0] ref_md(logic [2:0] o, logic [31:0] a, logic [31:0] b);
        longint sa, sbv, q, r;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        res = '0;
        case (o)
            OP_MULT:  res = sa * sbv;
            OP_MULTU: res = {32'b0, a} * {32'b0, b};
            OP_DIV, OP_DIVU: begin
                if (b == 0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else if (o == OP_DIV) begin
                    q = sa / sbv;
                    r = sa % sbv;
                    res = {r[31:0], q[31:0]};
                end else begin
                    res = {a % b, a / b};
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pending op", cyc);
            end else begin
                e = exp_q.pop_front();
                $display("done %s: hi=%h lo=%h", e.name, hi, lo);
                chk({e.name, " hi"}, 64'(hi), 64'(e.hi));
                chk({e.name, " lo"}, 64'(lo), 64'(e.lo));
                chk({e.name, " latency"}, 64'(cyc - e.c0), 64'd34);
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && start && busy) begin
            total++;
            $display("FAIL start_while_busy at cycle %0d", cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Called at a negedge; returns just after the accepting posedge.
    task automatic issue(logic [2:0] o, logic [31:0] a, logic [31:0] b, string name);
        logic [63:0] r;
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (!o[2]) begin
            r = ref_md(o, a, b);
            exp_q.push_back('{r[63:32], r[31:0], cyc, name});
            m_hi = r[63:32];
            m_lo = r[31:0];
        end else if (o == OP_MTHI) begin
            m_hi = a;
        end else if (o == OP_MTLO) begin
            m_lo = a;
        end
    endtask

    task automatic mt(logic [2:0] o, logic [31:0] a, string name);
        issue(o, a, 32'h0, name);
        @(negedge clk);
        $display("%s: hi=%h lo=%h", name, hi, lo);
        chk({name, " hi"}, 64'(hi), 64'(m_hi));
        chk({name, " lo"}, 64'(lo), 64'(m_lo));
        chk({name, " busy"}, 64'(busy), 64'd0);
    endtask

    // Returns at the negedge on which done is seen, so a back-to-back issue can follow.
    task automatic wait_done(output int bc);
        bit seen;
        bc = 0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) seen = 1;
        end
        if (!seen) begin
            total++;
            $display("FAIL wait_done: got no done within 100 cycles, required done");
        end
    endtask

    task automatic run_md(logic [2:0] o, logic [31:0] a, logic [31:0] b, string name);
        int bc;
        issue(o, a, b, name);
        wait_done(bc);
        chk({name, " busy_cycles"}, 64'(bc), 64'd34);
    endtask

    initial begin
        int bc;
        logic [31:0] save_hi, save_lo, ra, rb;
        logic [2:0] ro;

        repeat (3) @(negedge clk);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_md(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        @(negedge clk);
        chk("done_pulse_width", 64'(done), 64'd0);
        run_md(OP_MULT, 32'hFFFF_FFF9, 32'd3, "mult_m7x3");
        run_md(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7d2");
        run_md(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_md(OP_DIVU, 32'h0000_1234, 32'd0, "divu_by0");
        run_md(OP_DIV, 32'hFFFF_FF00, 32'd0, "div_neg_by0");

        // Back-to-back: the second start lands on the done cycle of the first.
        run_md(OP_MULT, 32'd5, 32'd6, "b2b_first");
        run_md(OP_DIVU, 32'd100, 32'd7, "b2b_second");

        // Asynchronous reset in the middle of CALC.
        issue(OP_MULT, 32'd12345, 32'd678, "mult_reset");
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midreset busy", 64'(busy), 64'd0);
        chk("midreset hi", 64'(hi), 64'd0);
        chk("midreset lo", 64'(lo), 64'd0);
        chk("midreset done", 64'(done), 64'd0);
        exp_q.delete();
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_md(OP_MULT, 32'hFFFF_1234, 32'h0000_5678, "mult_after_reset");

        // Flush mid-operation keeps HI/LO and suppresses done.
        mt(OP_MTHI, 32'hA5A5_A5A5, "mthi_a5");
        save_hi = m_hi;
        save_lo = m_lo;
        issue(OP_MULT, 32'h1357_9BDF, 32'h2468_ACE0, "mult_flushed");
        void'(exp_q.pop_back());
        m_hi = save_hi;
        m_lo = save_lo;
        repeat (19) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush busy", 64'(busy), 64'd0);
        chk("flush hi", 64'(hi), 64'(32'hA5A5_A5A5));
        repeat (40) @(negedge clk);
        chk("flush lo_kept", 64'(lo), 64'(m_lo));

        // Flush together with start in IDLE drops the start.
        op = OP_MTLO; src_a = 32'hDEAD_BEEF; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_start lo", 64'(lo), 64'(m_lo));
        op = OP_DIV; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_start busy", 64'(busy), 64'd0);

        // Reserved op codes are ignored.
        op = 3'b110; src_a = 32'h1111_2222; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("op110 busy", 64'(busy), 64'd0);
        chk("op110 hi", 64'(hi), 64'(m_hi));
        chk("op110 lo", 64'(lo), 64'(m_lo));

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 5));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'h0;
            if ($urandom_range(0, 7) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(1, 31);
            if (ro[2]) mt(ro, ra, $sformatf("rnd%0d_mt", i));
            else       run_md(ro, ra, rb, $sformatf("rnd%0d_op%0d", i, ro));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
